// File: rtl/cpu_consts.sv
// Shared CPU constants for the multiply/divide unit.
// md_op_t    : M-extension operation encoding (funct3 order).
// md_state_t : md_unit control states.
package cpu_consts;

  typedef enum logic [2:0] {
    MD_MUL    = 3'd0,
    MD_MULH   = 3'd1,
    MD_MULHSU = 3'd2,
    MD_MULHU  = 3'd3,
    MD_DIV    = 3'd4,
    MD_DIVU   = 3'd5,
    MD_REM    = 3'd6,
    MD_REMU   = 3'd7
  } md_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } md_state_t;

  localparam int unsigned MD_WORD_BITS = 32;

endpackage

// File: rtl/md_divider.sv
// Unsigned radix-2 restoring divider, one quotient bit per cycle.
// Ports:
//   clk, reset            : clock, synchronous active-high reset
//   i_start               : load operands and bit count
//   i_kill                : abandon the running division
//   i_dividend, i_divisor : unsigned magnitudes (dividend left-aligned to the count)
//   i_count               : number of quotient bits to produce
//   o_quotient_c          : quotient after the current step (combinational)
//   o_remainder_c         : remainder after the current step (combinational)
//   o_last_c              : the current step is the final one
module md_divider #(
  parameter int unsigned XLEN  = 64,
  parameter int unsigned CNT_W = $clog2(XLEN + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_start,
  input  logic             i_kill,
  input  logic [XLEN-1:0]  i_dividend,
  input  logic [XLEN-1:0]  i_divisor,
  input  logic [CNT_W-1:0] i_count,
  output logic [XLEN-1:0]  o_quotient_c,
  output logic [XLEN-1:0]  o_remainder_c,
  output logic             o_last_c
);

  logic [XLEN-1:0]  r_rem;
  logic [XLEN-1:0]  r_quo;
  logic [XLEN-1:0]  r_div;
  logic [CNT_W-1:0] r_cnt;
  logic [XLEN:0]    w_rem_shift;
  logic [XLEN-1:0]  w_diff;
  logic             w_ge;

  // Single restoring step; the quotient register doubles as the dividend shifter.
  always_comb begin
    w_rem_shift   = {r_rem, r_quo[XLEN-1]};
    w_ge          = (w_rem_shift >= {1'b0, r_div});
    w_diff        = w_rem_shift[XLEN-1:0] - r_div;
    o_quotient_c  = {r_quo[XLEN-2:0], w_ge};
    o_remainder_c = w_ge ? w_diff : w_rem_shift[XLEN-1:0];
    o_last_c      = (r_cnt == CNT_W'(1));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rem <= '0;
      r_quo <= '0;
      r_div <= '0;
      r_cnt <= '0;
    end else if (i_kill) begin
      r_cnt <= '0;
    end else if (i_start) begin
      r_rem <= '0;
      r_quo <= i_dividend;
      r_div <= i_divisor;
      r_cnt <= i_count;
    end else if (r_cnt != '0) begin
      r_rem <= o_remainder_c;
      r_quo <= o_quotient_c;
      r_cnt <= r_cnt - CNT_W'(1);
    end
  end

endmodule

// File: rtl/md_unit.sv
// Integer multiply/divide unit (RV M-extension, including W variants).
// Optional feature macro: MD_FAST_MUL_EN (single-cycle combinational multiplier).
// Ports:
//   clk, reset                : clock, synchronous active-high reset
//   req_valid / req_ready     : request handshake (ready only in IDLE)
//   req_op, req_word          : md_op_t operation, 32-bit W variant
//   req_a, req_b, req_tag     : operands and destination tag
//   flush                     : kill any in-flight operation
//   resp_valid / resp_ready   : response handshake
//   resp_data, resp_tag       : result and its tag
//   busy                      : unit is not IDLE
module md_unit
  import cpu_consts::*;
#(
  parameter int unsigned XLEN  = 64,
  parameter int unsigned TAG_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [2:0]       req_op,
  input  logic             req_word,
  input  logic [XLEN-1:0]  req_a,
  input  logic [XLEN-1:0]  req_b,
  input  logic [TAG_W-1:0] req_tag,
  input  logic             flush,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [XLEN-1:0]  resp_data,
  output logic [TAG_W-1:0] resp_tag,
  output logic             busy
);

  localparam int unsigned CNT_W = $clog2(XLEN + 1);
  localparam int unsigned PW    = 2 * XLEN;

  // Sign-extend the low word for W variants.
  function automatic logic [XLEN-1:0] f_wext(input logic word, input logic [XLEN-1:0] v);
    return word ? XLEN'($signed(v[MD_WORD_BITS-1:0])) : v;
  endfunction

  // Apply the product sign, then pick the high half or the (extended) low half.
  function automatic logic [XLEN-1:0] f_mul_res(input logic mulh, input logic word,
                                                input logic neg, input logic [PW-1:0] prod);
    logic [PW-1:0] p;
    p = neg ? -prod : prod;
    return mulh ? p[PW-1:XLEN] : f_wext(word, p[XLEN-1:0]);
  endfunction

  md_state_t        r_state, w_state_next;
  md_op_t           w_op;
  logic             w_word, w_is_div, w_is_rem, w_mulh, w_a_signed, w_b_signed;
  logic             w_a_neg, w_b_neg, w_div_zero, w_div_ovf, w_fast_done, w_accept, w_last;
  logic [XLEN-1:0]  w_a_ext, w_b_ext, w_a_mag, w_b_mag, w_min_n, w_special, w_dividend;
  logic [XLEN-1:0]  w_quo_next, w_rem_next, w_div_result, w_iter_result, w_fast_result;
  logic [CNT_W-1:0] w_count;
  logic [XLEN-1:0]  r_resp_data;
  logic [TAG_W-1:0] r_resp_tag;
  logic             r_word, r_is_rem, r_q_neg, r_r_neg;

  // Operand decode, width extension and sign-magnitude conversion at accept.
  always_comb begin
    w_op       = md_op_t'(req_op);
    w_word     = (XLEN == 64) && req_word;
    w_is_div   = req_op[2];
    w_is_rem   = req_op[2] & req_op[1];
    w_mulh     = !req_op[2] && (req_op[1:0] != 2'b00) && !w_word;
    w_a_signed = (w_op == MD_DIV) || (w_op == MD_REM) || (w_mulh && (w_op != MD_MULHU));
    w_b_signed = (w_op == MD_DIV) || (w_op == MD_REM) || (w_mulh && (w_op == MD_MULH));
    w_a_ext    = w_word ? (w_a_signed ? XLEN'($signed(req_a[31:0])) : XLEN'(req_a[31:0])) : req_a;
    w_b_ext    = w_word ? (w_b_signed ? XLEN'($signed(req_b[31:0])) : XLEN'(req_b[31:0])) : req_b;
    w_a_neg    = w_a_signed & w_a_ext[XLEN-1];
    w_b_neg    = w_b_signed & w_b_ext[XLEN-1];
    w_a_mag    = w_a_neg ? -w_a_ext : w_a_ext;
    w_b_mag    = w_b_neg ? -w_b_ext : w_b_ext;
    w_min_n    = w_word ? (~XLEN'(0) << 31) : (XLEN'(1) << (XLEN - 1));
    w_div_zero = w_is_div && (w_b_ext == '0);
    w_div_ovf  = w_is_div && w_b_signed && (w_a_ext == w_min_n) && (w_b_ext == '1);
    w_special  = w_div_zero ? (w_is_rem ? w_a_ext : '1) : (w_is_rem ? '0 : w_min_n);
    // Left-align a W dividend so that 32 steps leave the quotient in the low bits.
    w_dividend = w_word ? (w_a_mag << (XLEN - 32)) : w_a_mag;
    w_count    = w_word ? CNT_W'(32) : CNT_W'(XLEN);
    w_accept   = req_valid && (r_state == IDLE) && !flush;
  end

  md_divider #(.XLEN(XLEN), .CNT_W(CNT_W)) u_div (
    .clk          (clk),
    .reset        (reset),
    .i_start      (w_accept && !w_fast_done),
    .i_kill       (flush),
    .i_dividend   (w_dividend),
    .i_divisor    (w_b_mag),
    .i_count      (w_count),
    .o_quotient_c (w_quo_next),
    .o_remainder_c(w_rem_next),
    .o_last_c     (w_last)
  );

  // Signs restored on the magnitude result of the final divider step.
  always_comb begin
    w_div_result = r_is_rem ? (r_r_neg ? -w_rem_next : w_rem_next)
                            : (r_q_neg ? -w_quo_next : w_quo_next);
    w_div_result = f_wext(r_word, w_div_result);
  end

`ifdef MD_FAST_MUL_EN
  logic [PW-1:0] w_prod_fast;

  always_comb begin
    w_prod_fast   = PW'(w_a_mag) * PW'(w_b_mag);
    w_fast_done   = !w_is_div || w_div_zero || w_div_ovf;
    w_fast_result = w_is_div ? f_wext(w_word, w_special)
                             : f_mul_res(w_mulh, w_word, w_a_neg ^ w_b_neg, w_prod_fast);
    w_iter_result = w_div_result;
  end
`else
  logic [PW-1:0]   r_mcand, r_prod, w_prod_next;
  logic [XLEN-1:0] r_mplier;
  logic            r_mulh, r_p_neg, r_is_div;

  always_comb begin
    w_prod_next   = r_prod + (r_mplier[0] ? r_mcand : '0);
    w_fast_done   = w_div_zero || w_div_ovf;
    w_fast_result = f_wext(w_word, w_special);
    w_iter_result = r_is_div ? w_div_result : f_mul_res(r_mulh, r_word, r_p_neg, w_prod_next);
  end

  // Shift-add multiplier on magnitudes; the divider's bit counter times it.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_mcand  <= '0;
      r_mplier <= '0;
      r_prod   <= '0;
      r_mulh   <= 1'b0;
      r_p_neg  <= 1'b0;
      r_is_div <= 1'b0;
    end else if (w_accept) begin
      r_mcand  <= PW'(w_a_mag);
      r_mplier <= w_b_mag;
      r_prod   <= '0;
      r_mulh   <= w_mulh;
      r_p_neg  <= w_a_neg ^ w_b_neg;
      r_is_div <= w_is_div;
    end else if (r_state == BUSY) begin
      r_prod   <= w_prod_next;
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
    end
  end
`endif

  // Request context and result register; the result only moves on accept or the last step.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_resp_data <= '0;
      r_resp_tag  <= '0;
      r_word      <= 1'b0;
      r_is_rem    <= 1'b0;
      r_q_neg     <= 1'b0;
      r_r_neg     <= 1'b0;
    end else if (w_accept) begin
      r_resp_tag <= req_tag;
      r_word     <= w_word;
      r_is_rem   <= w_is_rem;
      r_q_neg    <= w_a_neg ^ w_b_neg;
      r_r_neg    <= w_a_neg;
      if (w_fast_done) r_resp_data <= w_fast_result;
    end else if ((r_state == BUSY) && w_last) begin
      r_resp_data <= w_iter_result;
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_next;
  end

  // FSM next state; flush overrides every handshake.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_state_next = w_fast_done ? DONE : BUSY;
      BUSY:    if (w_last) w_state_next = DONE;
      DONE:    if (resp_ready) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
    if (flush) w_state_next = IDLE;
  end

  // FSM outputs, decoded from the state register only.
  always_comb begin
    req_ready  = (r_state == IDLE);
    busy       = (r_state != IDLE);
    resp_valid = (r_state == DONE);
  end

  assign resp_data = r_resp_data;
  assign resp_tag  = r_resp_tag;

endmodule

// File: tb/tb_md_unit.sv
// Scoreboard bench for md_unit (XLEN=64): directed vectors push expected
// result/tag/latency; a negedge monitor checks every response cycle.
module tb_md_unit;
  import cpu_consts::*;

  localparam int unsigned XLEN  = 64;
  localparam int unsigned TAG_W = 5;
  localparam int DIV64_LAT = 65;
  localparam int DIV32_LAT = 33;
`ifdef MD_FAST_MUL_EN
  localparam int MUL64_LAT = 1;
  localparam int MUL32_LAT = 1;
`else
  localparam int MUL64_LAT = 65;
  localparam int MUL32_LAT = 33;
`endif

  logic             clk = 1'b0;
  logic             reset, req_valid, req_ready, req_word, flush;
  logic             resp_valid, resp_ready, busy;
  logic [2:0]       req_op;
  logic [XLEN-1:0]  req_a, req_b, resp_data;
  logic [TAG_W-1:0] req_tag, resp_tag;

  typedef struct {
    logic [63:0] data;
    logic [4:0]  tag;
    int          lat;
    int          acc;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  logic seen     = 1'b0;

  md_unit #(.XLEN(XLEN), .TAG_W(TAG_W)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_word(req_word), .req_a(req_a), .req_b(req_b),
    .req_tag(req_tag), .flush(flush), .resp_valid(resp_valid),
    .resp_ready(resp_ready), .resp_data(resp_data), .resp_tag(resp_tag), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%h expected 0x%h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Response monitor: latency on first valid cycle, data/tag every valid cycle.
  always @(negedge clk) begin
    if (!reset && resp_valid) begin
      if (sb_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_resp: resp_valid=1 tag=%0d data=0x%h, none expected", resp_tag, resp_data);
      end else begin
        if (!seen) begin
          check("resp_latency", 64'(cyc - sb_q[0].acc + 1), 64'(sb_q[0].lat));
          seen = 1'b1;
        end
        check("resp_data", resp_data, sb_q[0].data);
        check("resp_tag", 64'(resp_tag), 64'(sb_q[0].tag));
        check("req_ready_in_done", 64'(req_ready), 64'd0);
        if (resp_ready) begin
          void'(sb_q.pop_front());
          seen = 1'b0;
        end
      end
    end
  end

  // Called just after a rising edge; returns just after the accept edge.
  task automatic issue(input md_op_t op, input logic w, input logic [63:0] a, input logic [63:0] b,
                       input logic [4:0] tag, input logic exp_resp, input logic [63:0] exp, input int lat);
    int   guard;
    exp_t e;
    guard = 0;
    while (!req_ready && guard < 500) begin
      @(posedge clk); #1;
      guard++;
    end
    check("accept_wait", 64'(req_ready), 64'd1);
    req_valid = 1'b1;
    req_op    = op;
    req_word  = w;
    req_a     = a;
    req_b     = b;
    req_tag   = tag;
    @(posedge clk); #1;
    req_valid = 1'b0;
    if (exp_resp) begin
      e.data = exp;
      e.tag  = tag;
      e.lat  = lat;
      e.acc  = cyc;
      sb_q.push_back(e);
    end
  endtask

  task automatic wait_idle();
    int guard;
    guard = 0;
    while ((busy || sb_q.size() != 0) && guard < 1000) begin
      @(posedge clk); #1;
      guard++;
    end
    check("drain", 64'(sb_q.size()), 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; req_valid = 1'b0; req_op = '0; req_word = 1'b0;
    req_a = '0; req_b = '0; req_tag = '0; flush = 1'b0; resp_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("rst_resp_valid", 64'(resp_valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_resp_data", resp_data, 64'd0);
    check("rst_resp_tag", 64'(resp_tag), 64'd0);
    check("rst_req_ready", 64'(req_ready), 64'd1);
    @(posedge clk); #1;

    issue(MD_DIV,    0, 64'd20, 64'hFFFFFFFFFFFFFFFD, 5'd1, 1, 64'hFFFFFFFFFFFFFFFA, DIV64_LAT);
    issue(MD_REM,    0, 64'd20, 64'hFFFFFFFFFFFFFFFD, 5'd2, 1, 64'd2, DIV64_LAT);
    issue(MD_DIVU,   0, 64'h1234, 64'd0, 5'd3, 1, 64'hFFFFFFFFFFFFFFFF, 1);
    issue(MD_REMU,   0, 64'h1234, 64'd0, 5'd4, 1, 64'h1234, 1);
    issue(MD_DIV,    1, 64'h80000000, 64'hFFFFFFFF, 5'd5, 1, 64'hFFFFFFFF80000000, 1);
    issue(MD_REM,    1, 64'h80000000, 64'hFFFFFFFF, 5'd6, 1, 64'd0, 1);
    issue(MD_MULHU,  0, 64'hFFFFFFFFFFFFFFFF, 64'd2, 5'd7, 1, 64'd1, MUL64_LAT);
    issue(MD_MUL,    1, 64'h7FFFFFFF, 64'd2, 5'd8, 1, 64'hFFFFFFFFFFFFFFFE, MUL32_LAT);
    issue(MD_MULH,   0, 64'hFFFFFFFFFFFFFFFE, 64'd3, 5'd9, 1, 64'hFFFFFFFFFFFFFFFF, MUL64_LAT);
    issue(MD_MULHSU, 0, 64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 5'd10, 1, 64'hFFFFFFFFFFFFFFFF, MUL64_LAT);
    issue(MD_MUL,    0, 64'h100000001, 64'h100000001, 5'd11, 1, 64'h0000000200000001, MUL64_LAT);
    issue(MD_DIVU,   1, 64'hFFFFFFFF00000007, 64'd2, 5'd12, 1, 64'd3, DIV32_LAT);
    issue(MD_REM,    1, 64'h00000000FFFFFFF9, 64'd2, 5'd13, 1, 64'hFFFFFFFFFFFFFFFF, DIV32_LAT);
    issue(MD_DIV,    0, 64'h8000000000000000, 64'hFFFFFFFFFFFFFFFF, 5'd14, 1, 64'h8000000000000000, 1);
    issue(MD_REM,    0, 64'h8000000000000000, 64'hFFFFFFFFFFFFFFFF, 5'd15, 1, 64'd0, 1);
    issue(MD_MULHU,  1, 64'h8000, 64'h10000, 5'd16, 1, 64'hFFFFFFFF80000000, MUL32_LAT);
    issue(MD_REM,    0, 64'hFFFFFFFFFFFFFF9C, 64'd7, 5'd17, 1, 64'hFFFFFFFFFFFFFFFE, DIV64_LAT);
    issue(MD_DIV,    0, 64'd100, 64'd7, 5'd18, 1, 64'd14, DIV64_LAT);

    // Flush mid-divide: no response, ready again the cycle after flush.
    issue(MD_DIV, 0, 64'd100, 64'd7, 5'd19, 0, 64'd0, 0);
    repeat (9) begin @(posedge clk); #1; end
    check("busy_before_flush", 64'(busy), 64'd1);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check("req_ready_after_flush", 64'(req_ready), 64'd1);
    check("busy_after_flush", 64'(busy), 64'd0);
    check("resp_valid_after_flush", 64'(resp_valid), 64'd0);
    issue(MD_MUL, 0, 64'd3, 64'd4, 5'd20, 1, 64'd12, MUL64_LAT);

    // Backpressure: result and tag held while resp_ready is low.
    wait_idle();
    resp_ready = 1'b0;
    issue(MD_REMU, 0, 64'h55, 64'd0, 5'd21, 1, 64'h55, 1);
    repeat (5) begin @(posedge clk); #1; end
    check("held_valid", 64'(resp_valid), 64'd1);
    resp_ready = 1'b1;

    // Reset in the middle of a divide discards it.
    wait_idle();
    issue(MD_DIVU, 0, 64'd1000, 64'd3, 5'd22, 0, 64'd0, 0);
    repeat (5) begin @(posedge clk); #1; end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("mid_rst_resp_valid", 64'(resp_valid), 64'd0);
    check("mid_rst_busy", 64'(busy), 64'd0);
    check("mid_rst_req_ready", 64'(req_ready), 64'd1);
    check("mid_rst_resp_data", resp_data, 64'd0);
    check("mid_rst_resp_tag", 64'(resp_tag), 64'd0);
    @(posedge clk); #1;
    issue(MD_DIVU, 0, 64'd1000, 64'd3, 5'd23, 1, 64'd333, DIV64_LAT);

    wait_idle();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
